// File: rtl/addr_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_dec_pkg
// Description : Shared definitions for the XY address-decrement pipeline:
//               direction bit indices for the one-hot out_dir vector and the
//               occupancy encoding of the main/skid storage pair.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_dec_pkg;

    // Bit positions inside the one-hot direction vector {L,S,N,W,E}
    localparam int DIR_E     = 0;
    localparam int DIR_W     = 1;
    localparam int DIR_N     = 2;
    localparam int DIR_S     = 3;
    localparam int DIR_L     = 4;
    localparam int DIR_W_NUM = 5;

    // Occupancy of the main + skid register pair
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

endpackage : addr_dec_pkg
`default_nettype wire

// File: rtl/addr_step.sv
`default_nettype none
// ============================================================================
// Module      : addr_step
// Description : Combinational one-hop step of a single relative address field.
//               Unsigned build: nonzero fields step towards zero by -1.
//               Signed build (ADDR_DEC_SIGNED_EN): two's complement fields
//               step towards zero (-1 if positive, +1 if negative) and the
//               most-negative value is reported as an error.
// Ports       : i_field    - AW-bit relative address
//               o_step_val - field moved one hop towards zero (field if zero)
//               o_nonzero  - field is not zero
//               o_neg      - field is negative (always 0 in unsigned build)
//               o_err      - field is the most-negative value (signed only)
// Macro       : ADDR_DEC_SIGNED_EN
// Revision    : 1.0 - initial release
// ============================================================================
module addr_step #(
    parameter int AW = 8
) (
    input  logic [AW-1:0] i_field,
    output logic [AW-1:0] o_step_val,
    output logic          o_nonzero,
    output logic          o_neg,
    output logic          o_err
);

    localparam logic [AW-1:0] c_one = AW'(1);

`ifdef ADDR_DEC_SIGNED_EN
    // 1 followed by zeros: has no positive counterpart, so it cannot be stepped
    localparam logic [AW-1:0] c_most_neg = {1'b1, {(AW-1){1'b0}}};

    always_comb begin
        o_nonzero  = |i_field;
        o_neg      = i_field[AW-1];
        o_err      = (i_field == c_most_neg);
        o_step_val = i_field;
        if (o_nonzero) begin
            o_step_val = o_neg ? (i_field + c_one) : (i_field - c_one);
        end
    end
`else
    always_comb begin
        o_nonzero  = |i_field;
        o_neg      = 1'b0;
        o_err      = 1'b0;
        o_step_val = i_field;
        if (o_nonzero) begin
            o_step_val = i_field - c_one;
        end
    end
`endif

endmodule : addr_step
`default_nettype wire

// File: rtl/addr_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : addr_dec_pipe
// Description : Registered XY-routing step for NoC head flits. Resolves X before
//               Y, emits a one-hot direction {L,S,N,W,E} and the addresses
//               stepped by one hop. Valid/ready on both sides with a 2-entry
//               (main + skid) buffer, so in_rdy is a flop and throughput is one
//               flit per cycle.
// Ports       : clk, rst_n (synchronous, active-low)
//               in_vld/in_rdy, in_xa, in_ya, in_data   - upstream flit
//               out_vld/out_rdy, out_xa, out_ya,
//               out_data, out_dir, out_err             - downstream flit
// Macro       : ADDR_DEC_SIGNED_EN - two's complement addresses, W/S
//               directions and out_err; undefined gives unsigned E/N/L only.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_dec_pipe
    import addr_dec_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [AW-1:0]        in_xa,
    input  logic [AW-1:0]        in_ya,
    input  logic [DW-1:0]        in_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [AW-1:0]        out_xa,
    output logic [AW-1:0]        out_ya,
    output logic [DW-1:0]        out_data,
    output logic [DIR_W_NUM-1:0] out_dir,
    output logic                 out_err
);

    // ------------------------------------------------------------------
    // Per-dimension step
    // ------------------------------------------------------------------
    logic [AW-1:0] w_x_step, w_y_step;
    logic          w_x_nz, w_y_nz, w_x_neg, w_y_neg, w_x_err, w_y_err;

    addr_step #(.AW(AW)) u_step_x (
        .i_field    (in_xa),
        .o_step_val (w_x_step),
        .o_nonzero  (w_x_nz),
        .o_neg      (w_x_neg),
        .o_err      (w_x_err)
    );

    addr_step #(.AW(AW)) u_step_y (
        .i_field    (in_ya),
        .o_step_val (w_y_step),
        .o_nonzero  (w_y_nz),
        .o_neg      (w_y_neg),
        .o_err      (w_y_err)
    );

    // X-before-Y priority. An unrepresentable field forces a local delivery
    // with the addresses untouched so the error is handled at this node.
    // In the unsigned build neg/err are constant 0, leaving W/S/err tied off.
    logic [AW-1:0]        w_xa_nxt, w_ya_nxt;
    logic [DIR_W_NUM-1:0] w_dir_nxt;
    logic                 w_err_nxt;

    always_comb begin
        w_xa_nxt  = in_xa;
        w_ya_nxt  = in_ya;
        w_dir_nxt = '0;
        w_err_nxt = 1'b0;
        if (w_x_err || w_y_err) begin
            w_err_nxt        = 1'b1;
            w_dir_nxt[DIR_L] = 1'b1;
        end else if (w_x_nz) begin
            w_xa_nxt = w_x_step;
            if (w_x_neg) w_dir_nxt[DIR_W] = 1'b1;
            else         w_dir_nxt[DIR_E] = 1'b1;
        end else if (w_y_nz) begin
            w_ya_nxt = w_y_step;
            if (w_y_neg) w_dir_nxt[DIR_S] = 1'b1;
            else         w_dir_nxt[DIR_N] = 1'b1;
        end else begin
            w_dir_nxt[DIR_L] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy FSM
    // ------------------------------------------------------------------
    occ_e r_state, w_state_nxt;
    logic r_in_rdy;
    logic w_accept, w_issue;
    logic w_ld_main_in, w_ld_main_skid, w_ld_skid;

    assign out_vld  = (r_state != EMPTY);
    assign in_rdy   = r_in_rdy;
    assign w_accept = in_vld & r_in_rdy;
    assign w_issue  = out_vld & out_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_in_rdy <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_in_rdy <= (w_state_nxt != FULL);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt  = ONE;
                    w_ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && !w_issue) begin
                    w_state_nxt = FULL;
                    w_ld_skid   = 1'b1;
                end else if (w_issue && !w_accept) begin
                    w_state_nxt = EMPTY;
                end else if (w_issue && w_accept) begin
                    w_ld_main_in = 1'b1;
                end
            end
            FULL: begin
                // in_rdy is low here, so only the drain side can move
                if (w_issue) begin
                    w_state_nxt    = ONE;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Main (output) and skid entries
    // ------------------------------------------------------------------
    logic [AW-1:0]        r_main_xa, r_main_ya, r_skid_xa, r_skid_ya;
    logic [DW-1:0]        r_main_data, r_skid_data;
    logic [DIR_W_NUM-1:0] r_main_dir, r_skid_dir;
    logic                 r_main_err, r_skid_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_xa   <= '0;
            r_main_ya   <= '0;
            r_main_data <= '0;
            r_main_dir  <= '0;
            r_main_err  <= 1'b0;
            r_skid_xa   <= '0;
            r_skid_ya   <= '0;
            r_skid_data <= '0;
            r_skid_dir  <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            if (w_ld_main_in) begin
                r_main_xa   <= w_xa_nxt;
                r_main_ya   <= w_ya_nxt;
                r_main_data <= in_data;
                r_main_dir  <= w_dir_nxt;
                r_main_err  <= w_err_nxt;
            end else if (w_ld_main_skid) begin
                r_main_xa   <= r_skid_xa;
                r_main_ya   <= r_skid_ya;
                r_main_data <= r_skid_data;
                r_main_dir  <= r_skid_dir;
                r_main_err  <= r_skid_err;
            end
            if (w_ld_skid) begin
                r_skid_xa   <= w_xa_nxt;
                r_skid_ya   <= w_ya_nxt;
                r_skid_data <= in_data;
                r_skid_dir  <= w_dir_nxt;
                r_skid_err  <= w_err_nxt;
            end
        end
    end

    assign out_xa   = r_main_xa;
    assign out_ya   = r_main_ya;
    assign out_data = r_main_data;
    assign out_dir  = r_main_dir;
    assign out_err  = r_main_err;

endmodule : addr_dec_pipe
`default_nettype wire

// File: doc/addr_dec_pipe.md
Name: addr_dec_pipe

Overview:
Registered, parametrised successor of the XY address decrement stage for head flits in the NoC router input path. It takes a head flit carrying X/Y relative addresses and computes one XY-routing step: output direction, plus the address stepped by one hop in the chosen dimension. It sits between the input buffer and the switch allocator. A valid/ready handshake with a 2-entry skid buffer gives full throughput and a registered in_rdy.

Parameters:
AW, 8, width of each of the X and Y address fields (bits); legal range 2..16
DW, 32, width of the payload passed through untouched

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
in_vld  input  1  input flit valid
in_rdy  output  1  input ready (registered)
in_xa  input  AW  X relative address
in_ya  input  AW  Y relative address
in_data  input  DW  payload
out_vld  output  1  output flit valid
out_rdy  input  1  downstream ready
out_xa  output  AW  X address after step
out_ya  output  AW  Y address after step
out_data  output  DW  payload, unchanged
out_dir  output  5  one-hot direction {L,S,N,W,E} = bits [4:0] = {4,3,2,1,0}
out_err  output  1  address-field error flag for this flit

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n). Reset: out_vld=0, in_rdy=1, out_xa/out_ya/out_data/out_dir=0, out_err=0; occupancy=EMPTY.
- Transfer on in_vld&in_rdy (accept) and on out_vld&out_rdy (issue).
- Step, unsigned mode (default): if xa!=0, dir=E and xa-1; else if ya!=0, dir=N and ya-1; else dir=L and both stay 0. X is always resolved before Y.
- Step is computed on accept; the result is stored with the payload.
- Storage: main register plus skid register. States:
  - EMPTY: accept -> ONE.
  - ONE: accept & !issue -> FULL. Issue & !accept -> EMPTY. Accept & issue -> ONE, with the new flit in main.
  - FULL: issue -> ONE, skid moves to main. No accept is possible.
- Latency: accept in cycle n -> out_vld in cycle n+1 when empty.
- Throughput: 1 flit/cycle while out_rdy=1.
- in_rdy is registered: in_rdy = (next state != FULL).
- Outputs stay stable while out_vld & !out_rdy.
- out_err = 0 in unsigned mode. It is defined only in signed mode.
- Reset mid-operation: both entries are discarded and the block returns to its reset values on the next edge. No partial flit is emitted.
- out_dir is exactly one-hot whenever out_vld=1.

Optional Feature:
ADDR_DEC_SIGNED_EN
- Defined: addresses are two's complement.
  - X resolved first: xa>0 -> dir=E, xa-1; xa<0 -> dir=W, xa+1.
  - Then Y: ya>0 -> dir=N, ya-1; ya<0 -> dir=S, ya+1.
  - Both zero -> L.
  - The most-negative value (1 followed by AW-1 zeros) in either field sets out_err=1. That flit is forced to dir=L with its addresses unchanged, so the error is handled locally.
- Undefined: unsigned behaviour only. W and S bits are tied to 0 and out_err is tied to 0.

Decomposition:
- Shared package addr_dec_pkg:
  - direction index constants DIR_E=0, DIR_W=1, DIR_N=2, DIR_S=3, DIR_L=4;
  - DIR_W_NUM=5;
  - occupancy encodings EMPTY/ONE/FULL.
- One combinational sub-module addr_step, instantiated once per dimension.
  - Inputs: an AW-bit field.
  - Outputs: stepped value, nonzero flag, sign (signed build), error flag.
- The top level holds the X-before-Y priority, the skid FSM and the registers.

Test Plan:
- Reset, then single flit xa=3, ya=2, out_rdy=1 -> next cycle out_dir=E (00001), out_xa=2, out_ya=2, data unchanged.
- xa=0, ya=1 -> dir=N (00100), out_ya=0. Then xa=0, ya=0 -> dir=L (10000), addresses 0.
- Back-pressure: hold out_rdy=0 and offer 3 flits.
  - Exactly 2 are accepted; in_rdy=0 from the cycle after the 2nd accept.
  - Outputs stay stable.
  - Release out_rdy -> the 2 flits drain in order, one per cycle.
- Streaming 100 random flits with out_rdy=1 -> one output per cycle, order preserved, addresses checked against a model.
- Assert rst_n=0 while FULL -> next edge out_vld=0, in_rdy=1. After release, the first new flit emerges correctly.
- ADDR_DEC_SIGNED_EN, AW=8:
  - xa=8'hFE -> dir=W, out_xa=8'hFF.
  - xa=0, ya=8'hFF -> dir=S, out_ya=0.
  - xa=8'h80 -> out_err=1, dir=L, addresses unchanged.
